// File: rtl/axi_stream_pattern_gen.sv
// AXI-Stream test-pattern source: emits bursts of fixed-length packets carrying
// byte-increment, beat-counter, PRBS-32 or constant data, with full tready back-pressure.
module axi_stream_pattern_gen #(
   parameter int DATA_WIDTH   = 64,
   parameter int LENGTH_WIDTH = 16,
   parameter int BURST_WIDTH  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_start,
   input  logic [LENGTH_WIDTH-1:0]    i_length,
   input  logic [BURST_WIDTH-1:0]     i_burst_num,
   input  logic [1:0]                 i_mode,
   input  logic [31:0]                i_seed,
   input  logic                       i_ready,
   output logic [DATA_WIDTH-1:0]      o_data,
   output logic                       o_valid,
   output logic [DATA_WIDTH/8-1:0]    o_keep,
   output logic                       o_last,
   output logic                       o_busy,
   output logic                       o_done
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int SHIFT      = $clog2(STRB_WIDTH);
   localparam int BIT_WIDTH  = (STRB_WIDTH == 1) ? 1 : SHIFT;
   localparam int BEATS_W    = LENGTH_WIDTH - BIT_WIDTH + 1;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

   state_t                   r_state;
   state_t                   w_next;
   logic [LENGTH_WIDTH-1:0]  r_length;
   logic [BEATS_W-1:0]       r_beats;
   logic [BURST_WIDTH-1:0]   r_bursts;
   logic [1:0]               r_mode;
   logic [31:0]              r_seed;
   logic [BEATS_W-1:0]       r_beat;
   logic [BURST_WIDTH-1:0]   r_pkt;
   logic [7:0]               r_byte;
   logic [31:0]              r_cnt;
   logic [31:0]              r_lfsr;

   logic [LENGTH_WIDTH:0]    w_sum;
   logic [BEATS_W-1:0]       w_beats;
   logic [LENGTH_WIDTH-1:0]  w_rem;
   logic [STRB_WIDTH-1:0]    w_keep_last;
   logic [DATA_WIDTH-1:0]    w_pat;
   logic                     w_load;
   logic                     w_hs;
   logic                     w_last;
   logic                     w_final_pkt;
   logic                     w_send;

   // One extra bit on the sum keeps ceil() exact when i_length is at its maximum.
   assign w_sum   = {1'b0, i_length} + (LENGTH_WIDTH + 1)'(STRB_WIDTH - 1);
   assign w_beats = BEATS_W'(w_sum >> SHIFT);
   assign w_rem   = r_length & LENGTH_WIDTH'(STRB_WIDTH - 1);

   assign w_send      = (r_state == S_SEND);
   assign w_load      = (r_state == S_IDLE) && i_start;
   assign w_hs        = w_send && i_ready;
   assign w_last      = (r_beat == r_beats - BEATS_W'(1));
   assign w_final_pkt = (r_pkt == r_bursts - BURST_WIDTH'(1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (i_start) w_next = (i_length == '0) ? S_DONE : S_SEND;
         S_SEND: if (w_hs && w_last && w_final_pkt) w_next = S_DONE;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Run configuration is captured once per run and never touched mid-run.
   always_ff @(posedge clk) begin
      if (w_load) begin
         r_length <= i_length;
         r_beats  <= w_beats;
         r_bursts <= (i_burst_num == '0) ? BURST_WIDTH'(1) : i_burst_num;
         r_mode   <= i_mode;
         r_seed   <= i_seed;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_beat <= '0;
         r_pkt  <= '0;
         r_byte <= '0;
         r_cnt  <= '0;
         r_lfsr <= '0;
      end else if (w_load) begin
         r_beat <= '0;
         r_pkt  <= '0;
         r_byte <= i_seed[7:0];
         r_cnt  <= i_seed;
         r_lfsr <= (i_seed == '0) ? 32'h0000_0001 : i_seed;
      end else if (w_hs) begin
         r_byte <= r_byte + 8'd1;
         r_cnt  <= r_cnt + 32'd1;
         // Fibonacci taps for x^32 + x^22 + x^2 + x + 1
         r_lfsr <= {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
         if (w_last) begin
            r_beat <= '0;
            r_pkt  <= r_pkt + BURST_WIDTH'(1);
         end else begin
            r_beat <= r_beat + BEATS_W'(1);
         end
      end
   end

   always_comb begin
      w_keep_last = '0;
      for (int i = 0; i < STRB_WIDTH; i++)
         w_keep_last[i] = (w_rem == '0) || (i < int'(w_rem));
   end

   always_comb begin
      w_pat = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         case (r_mode)
            2'd0:    w_pat[i] = r_byte[i % 8];
            2'd1:    w_pat[i] = (i < 32) ? r_cnt[i % 32] : 1'b0;
            2'd2:    w_pat[i] = r_lfsr[i % 32];
            default: w_pat[i] = r_seed[i % 32];
         endcase
      end
   end

   assign o_valid = w_send;
   assign o_data  = w_send ? w_pat : '0;
   assign o_keep  = w_send ? (w_last ? w_keep_last : '1) : '0;
   assign o_last  = w_send && w_last;
   assign o_busy  = (r_state != S_IDLE);
   assign o_done  = (r_state == S_DONE);

endmodule

// File: tb/tb_axi_stream_pattern_gen.sv
// Directed bench for axi_stream_pattern_gen at DATA_WIDTH=64 with hand-computed beats.
module tb_axi_stream_pattern_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic [15:0] i_length;
   logic [7:0]  i_burst_num;
   logic [1:0]  i_mode;
   logic [31:0] i_seed;
   logic        i_ready;
   logic [63:0] o_data;
   logic        o_valid;
   logic [7:0]  o_keep;
   logic        o_last;
   logic        o_busy;
   logic        o_done;

   int checks = 0;
   int fails  = 0;

   axi_stream_pattern_gen #(.DATA_WIDTH(64), .LENGTH_WIDTH(16), .BURST_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_length(i_length),
      .i_burst_num(i_burst_num), .i_mode(i_mode), .i_seed(i_seed), .i_ready(i_ready),
      .o_data(o_data), .o_valid(o_valid), .o_keep(o_keep), .o_last(o_last),
      .o_busy(o_busy), .o_done(o_done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [15:0] len, input logic [7:0] bn,
                            input logic [1:0] md, input logic [31:0] sd);
      i_length = len; i_burst_num = bn; i_mode = md; i_seed = sd; i_ready = 1'b1;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; i_start = 1'b1; i_length = 16'd8; i_burst_num = 8'd1;
      i_mode = 2'd0; i_seed = 32'd0; i_ready = 1'b1;
      tick(); tick();
      if ({o_valid, o_last, o_busy, o_done} !== 4'b0000) begin fails++; $display("FAIL reset_ctrl: got %b want 0000", {o_valid, o_last, o_busy, o_done}); end checks++;
      if (o_data !== 64'd0) begin fails++; $display("FAIL reset_data: got %h want 0", o_data); end checks++;
      if (o_keep !== 8'h00) begin fails++; $display("FAIL reset_keep: got %h want 00", o_keep); end checks++;
      rst = 1'b0; i_start = 1'b0;
      tick();
      if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_start_priority busy: got %b want 0", o_busy); end checks++;
   endtask

   task automatic test_basic;
      start_run(16'd20, 8'd1, 2'd0, 32'd0);
      for (int b = 0; b < 3; b++) begin
         logic [7:0] lane;
         lane = 8'(b);
         if (o_valid !== 1'b1) begin fails++; $display("FAIL basic_valid beat %0d: got %b want 1", b, o_valid); end checks++;
         if (o_data !== {8{lane}}) begin fails++; $display("FAIL basic_data beat %0d: got %h want %h", b, o_data, {8{lane}}); end checks++;
         if (o_keep !== ((b == 2) ? 8'h0F : 8'hFF)) begin fails++; $display("FAIL basic_keep beat %0d: got %h", b, o_keep); end checks++;
         if (o_last !== (b == 2)) begin fails++; $display("FAIL basic_last beat %0d: got %b", b, o_last); end checks++;
         tick();
      end
      if ({o_valid, o_busy, o_done} !== 3'b011) begin fails++; $display("FAIL basic_done: got %b want 011", {o_valid, o_busy, o_done}); end checks++;
      tick();
      if ({o_busy, o_done} !== 2'b00) begin fails++; $display("FAIL basic_idle: got %b want 00", {o_busy, o_done}); end checks++;
   endtask

   task automatic test_stall;
      logic rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      int idx = 0;
      start_run(16'd20, 8'd1, 2'd0, 32'd0);
      for (int c = 0; c < 5; c++) begin
         logic [7:0] lane;
         lane = 8'(idx);
         if (o_valid !== 1'b1) begin fails++; $display("FAIL stall_valid cycle %0d: got %b want 1", c, o_valid); end checks++;
         if (o_data !== {8{lane}}) begin fails++; $display("FAIL stall_data cycle %0d: got %h want %h", c, o_data, {8{lane}}); end checks++;
         if (o_keep !== ((idx == 2) ? 8'h0F : 8'hFF)) begin fails++; $display("FAIL stall_keep cycle %0d: got %h", c, o_keep); end checks++;
         if (o_last !== (idx == 2)) begin fails++; $display("FAIL stall_last cycle %0d: got %b", c, o_last); end checks++;
         i_ready = rdy[c];
         tick();
         if (rdy[c]) idx++;
      end
      i_ready = 1'b1;
      if (o_done !== 1'b1) begin fails++; $display("FAIL stall_done: got %b want 1", o_done); end checks++;
      tick();
   endtask

   task automatic test_burst;
      start_run(16'd16, 8'd3, 2'd1, 32'd5);
      for (int b = 0; b < 6; b++) begin
         if (b == 1) begin i_start = 1'b1; i_length = 16'd0; i_mode = 2'd3; end
         if (b == 2) i_start = 1'b0;
         if (o_valid !== 1'b1) begin fails++; $display("FAIL burst_valid beat %0d: got %b want 1", b, o_valid); end checks++;
         if (o_data !== 64'(5 + b)) begin fails++; $display("FAIL burst_data beat %0d: got %h want %h", b, o_data, 64'(5 + b)); end checks++;
         if (o_keep !== 8'hFF) begin fails++; $display("FAIL burst_keep beat %0d: got %h want ff", b, o_keep); end checks++;
         if (o_last !== (b % 2 == 1)) begin fails++; $display("FAIL burst_last beat %0d: got %b", b, o_last); end checks++;
         tick();
      end
      if (o_done !== 1'b1) begin fails++; $display("FAIL burst_done: got %b want 1", o_done); end checks++;
      tick();
   endtask

   task automatic test_zero_len;
      start_run(16'd0, 8'd1, 2'd0, 32'd0);
      if ({o_valid, o_busy, o_done} !== 3'b011) begin fails++; $display("FAIL zero_len_done: got %b want 011", {o_valid, o_busy, o_done}); end checks++;
      tick();
      if ({o_valid, o_busy, o_done} !== 3'b000) begin fails++; $display("FAIL zero_len_idle: got %b want 000", {o_valid, o_busy, o_done}); end checks++;
   endtask

   task automatic test_prbs;
      logic [31:0] exp [5] = '{32'h1, 32'h3, 32'h6, 32'hD, 32'h1B};
      start_run(16'd40, 8'd0, 2'd2, 32'd0);
      for (int b = 0; b < 5; b++) begin
         if (o_data !== {2{exp[b]}}) begin fails++; $display("FAIL prbs_data beat %0d: got %h want %h", b, o_data, {2{exp[b]}}); end checks++;
         if (o_last !== (b == 4)) begin fails++; $display("FAIL prbs_last beat %0d: got %b", b, o_last); end checks++;
         tick();
      end
      if (o_done !== 1'b1) begin fails++; $display("FAIL prbs_done_burst0: got %b want 1", o_done); end checks++;
      tick();
   endtask

   task automatic test_const;
      start_run(16'd9, 8'd2, 2'd3, 32'hDEADBEEF);
      for (int b = 0; b < 4; b++) begin
         if (o_data !== 64'hDEADBEEF_DEADBEEF) begin fails++; $display("FAIL const_data beat %0d: got %h", b, o_data); end checks++;
         if (o_keep !== ((b % 2 == 1) ? 8'h01 : 8'hFF)) begin fails++; $display("FAIL const_keep beat %0d: got %h", b, o_keep); end checks++;
         if (o_last !== (b % 2 == 1)) begin fails++; $display("FAIL const_last beat %0d: got %b", b, o_last); end checks++;
         tick();
      end
      if (o_done !== 1'b1) begin fails++; $display("FAIL const_done: got %b want 1", o_done); end checks++;
      tick();
   endtask

   task automatic test_reset_mid;
      start_run(16'd32, 8'd1, 2'd0, 32'h10);
      if (o_data !== {8{8'h10}}) begin fails++; $display("FAIL rstmid_beat1: got %h", o_data); end checks++;
      tick();
      if (o_data !== {8{8'h11}}) begin fails++; $display("FAIL rstmid_beat2: got %h", o_data); end checks++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      if ({o_valid, o_last, o_busy, o_done} !== 4'b0000) begin fails++; $display("FAIL rstmid_ctrl: got %b want 0000", {o_valid, o_last, o_busy, o_done}); end checks++;
      if (o_data !== 64'd0 || o_keep !== 8'h00) begin fails++; $display("FAIL rstmid_data_keep: got %h/%h want 0/0", o_data, o_keep); end checks++;
      start_run(16'd32, 8'd1, 2'd0, 32'h10);
      for (int b = 0; b < 4; b++) begin
         logic [7:0] lane;
         lane = 8'(8'h10 + b);
         if (o_data !== {8{lane}}) begin fails++; $display("FAIL rstmid_replay beat %0d: got %h want %h", b, o_data, {8{lane}}); end checks++;
         if (o_last !== (b == 3)) begin fails++; $display("FAIL rstmid_replay_last beat %0d: got %b", b, o_last); end checks++;
         tick();
      end
      if (o_done !== 1'b1) begin fails++; $display("FAIL rstmid_done: got %b want 1", o_done); end checks++;
      tick();
   endtask

   initial begin
      rst = 1'b1; i_start = 1'b0; i_length = '0; i_burst_num = '0;
      i_mode = '0; i_seed = '0; i_ready = 1'b1;
      test_reset();
      test_basic();
      test_stall();
      test_burst();
      test_zero_len();
      test_prbs();
      test_const();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end

endmodule
